lut_acc_i8_i16: RTL and testbench
=================================

Name: lut_acc_i8_i16

Overview:
- Downstream consumer of the 8-bit LUT adder/subtractor stage. Takes its signed 8-bit result `y` as a stream.
- Accumulates blocks of N signed samples into a wider signed sum and presents each block total with a valid/ready handshake.
- Reports signed overflow per block.
- Sits between the LUT arithmetic stage and any checker or next pipeline stage in the CI designs.

Parameters:
- N, 4, samples per block (N >= 2).
- ACC_W, 16, accumulator and output width in bits (ACC_W >= 8).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous block abort; highest priority after reset.
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  8  signed sample, normally the adder's y.
- in_ready  out  1  block can accept a sample.
- out_valid  out  1  block sum is available.
- out_ready  in  1  downstream accepts the sum.
- out_sum  out  ACC_W  signed block sum.
- out_ovf  out  1  a signed overflow occurred in this block.
- out_cnt  out  $clog2(N+1)  samples accepted so far in the current block.

Behaviour:
- Reset (reset=0, async): state=ACCUM, acc=0, cnt=0, ovf=0, out_sum=0, out_valid=0, out_ovf=0.
  - in_ready=0 while reset is low.
  - Release takes effect at the next clock edge.
- States: ACCUM and HOLD.
- ACCUM:
  - in_ready=1, out_valid=0.
  - Accept on in_valid && in_ready.
  - On accept: acc <= acc + sext(in_data) modulo 2^ACC_W (wrap-around, no saturation).
  - On accept: ovf <= ovf | signed_overflow(acc, sext(in_data)). Overflow means both operands share a sign and the result sign differs.
  - On accept: cnt <= cnt + 1.
- Block completion (accept when cnt==N-1):
  - out_sum <= final acc value, out_ovf <= final ovf.
  - acc, cnt and ovf return to 0; state -> HOLD.
  - out_valid rises the cycle after the Nth accept, giving latency 1 cycle.
- HOLD:
  - out_valid=1, in_ready=0.
  - out_sum and out_ovf are stable until the handshake completes.
  - in_valid is ignored; no sample is consumed.
  - On out_ready: state -> ACCUM, out_valid=0 next cycle.
- Simultaneous events in HOLD: if out_ready and in_valid are both high, only the output handshake completes. The input is not accepted that cycle (no bypass).
- Throughput: at most N samples per N+1 cycles when out_ready is held high.
- clear=1:
  - acc, cnt, ovf <= 0; state -> ACCUM; out_valid <= 0.
  - Any pending HOLD result is discarded; out_sum keeps its old value, but that value is undefined to consumers.
  - A sample presented in the same cycle as clear is dropped.
- out_cnt reflects cnt: it is 0 in HOLD and after completion.
- Reset mid-block or mid-HOLD: immediate return to reset values, and no output handshake occurs.
- All outputs are registered. There is no combinational path from in_* to out_*. in_ready depends only on state and reset.

Decomposition:
- Shared package lut_acc_pkg:
  - state enum {ACCUM, HOLD};
  - default constants ACC_W_DEF=16 and N_DEF=4;
  - sign-extension helper function.
- One natural sub-module, lut_add_ovf:
  - combinational ACC_W-bit signed add of acc plus the sign-extended sample;
  - produces the sum and an overflow bit;
  - is instantiated once in the datapath.
- The control FSM and counter stay in the top module.

Test Plan:
- Default params, adder y=4 (a=1, b=-3) fed as samples 4, 1, 0xFD, 10 with out_ready=1 -> out_valid one cycle after the 4th accept, out_sum=16'h000C, out_ovf=0, then in_ready=1 the following cycle.
- Backpressure: complete a block of 1,2,3,4, hold out_ready=0 for 5 cycles while in_valid=1 with data 7 -> out_sum=10 stable, in_ready=0 throughout, out_cnt=0. Then raise out_ready: the next block starts with 7 accepted the cycle after the handshake.
- Overflow, ACC_W=8 instance: samples 127, 1, 0, 0 -> out_sum=8'h80, out_ovf=1. The next block 1, 1, 1, 1 -> out_sum=4, out_ovf=0.
- Negative accumulation, default params: samples 0x80, 0x80, 0x80, 0x80 -> out_sum=16'hFE00 (-512), out_ovf=0.
- clear after 2 samples (5, 6), then samples 1, 1, 1, 1 -> out_sum=4. Also assert clear during HOLD -> out_valid drops next cycle and in_ready=1.
- Assert reset low asynchronously mid-block (cnt=3) -> in_ready and out_valid go to 0 immediately and out_cnt=0. After release, samples 2, 2, 2, 2 -> out_sum=8.

Source files
------------

// File: rtl/lut_acc_pkg.sv
// Shared types and helpers for the signed LUT-result block accumulator.
package lut_acc_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam int ACC_W_DEF = 16;
  localparam int N_DEF     = 4;

  // Wide sign extension of an 8-bit sample; callers cast down to their width.
  function automatic logic [63:0] sext8(input logic [7:0] v);
    return {{56{v[7]}}, v};
  endfunction

endpackage

// File: rtl/lut_acc_i8_i16_add.sv
// Combinational wrap-around add of accumulator and sign-extended sample with signed overflow flag.
module lut_add_ovf
  import lut_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [7:0]       sample,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W-1:0] b_s;

  // Overflow: operands agree in sign but the wrapped result does not.
  always_comb begin
    b_s = ACC_W'(sext8(sample));
    sum = acc + b_s;
    ovf = (acc[ACC_W-1] == b_s[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
  end

endmodule

// File: rtl/lut_acc_i8_i16.sv
// Block accumulator: sums N signed 8-bit samples into ACC_W bits and hands each total out via valid/ready.
module lut_acc_i8_i16
  import lut_acc_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_sum,
  output logic                     out_ovf,
  output logic [$clog2(N+1)-1:0]   out_cnt
);

  localparam int CNT_W = $clog2(N + 1);

  state_e           state_r;
  state_e           state_s;
  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] sum_s;
  logic             ovf_r;
  logic             add_ovf_s;
  logic [CNT_W-1:0] cnt_r;
  logic             accept_s;
  logic             last_s;
  logic [ACC_W-1:0] out_sum_r;
  logic             out_ovf_r;
  logic             out_valid_r;

  lut_add_ovf #(.ACC_W(ACC_W)) u_add (
    .acc    (acc_r),
    .sample (in_data),
    .sum    (sum_s),
    .ovf    (add_ovf_s)
  );

  // in_ready is forced low while reset is asserted, independent of the clock.
  assign in_ready  = reset && (state_r == ACCUM);
  assign out_valid = out_valid_r;
  assign out_sum   = out_sum_r;
  assign out_ovf   = out_ovf_r;
  assign out_cnt   = cnt_r;

  // Accept qualification and next-state; clear overrides any pending handshake.
  always_comb begin
    accept_s = in_valid && (state_r == ACCUM) && !clear;
    last_s   = accept_s && (cnt_r == CNT_W'(N - 1));
    state_s  = state_r;
    if (clear) begin
      state_s = ACCUM;
    end else begin
      case (state_r)
        ACCUM:   if (last_s) state_s = HOLD;  else state_s = ACCUM;
        HOLD:    if (out_ready) state_s = ACCUM; else state_s = HOLD;
        default: state_s = ACCUM;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ACCUM;
    end else begin
      state_r <= state_s;
    end
  end

  // Accumulator, sample counter, sticky overflow and registered block result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_r       <= '0;
      cnt_r       <= '0;
      ovf_r       <= 1'b0;
      out_sum_r   <= '0;
      out_ovf_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (clear) begin
      acc_r       <= '0;
      cnt_r       <= '0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (last_s) begin
      out_sum_r   <= sum_s;
      out_ovf_r   <= ovf_r | add_ovf_s;
      out_valid_r <= 1'b1;
      acc_r       <= '0;
      cnt_r       <= '0;
      ovf_r       <= 1'b0;
    end else if (accept_s) begin
      acc_r <= sum_s;
      ovf_r <= ovf_r | add_ovf_s;
      cnt_r <= cnt_r + CNT_W'(1);
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

endmodule

// File: tb/tb_lut_acc_i8_i16.sv
// Directed plus randomized bench for lut_acc_i8_i16 at ACC_W=16 and ACC_W=8 against an integer block model.
module tb_lut_acc_i8_i16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        out_ready = 1'b0;

  logic        in_ready_a, out_valid_a, out_ovf_a;
  logic [15:0] out_sum_a;
  logic [2:0]  out_cnt_a;
  logic        in_ready_b, out_valid_b, out_ovf_b;
  logic [7:0]  out_sum_b;
  logic [2:0]  out_cnt_b;

  int tests = 0;
  int fails = 0;

  // Model state per instance: 0 -> ACC_W=16, 1 -> ACC_W=8
  int     wid [2] = '{16, 8};
  int     m_cnt [2];
  bit     m_hold [2];
  longint m_acc [2];
  bit     m_ovf [2];
  longint m_sum [2];
  bit     m_sovf [2];

  lut_acc_i8_i16 #(.N(4), .ACC_W(16)) dut_a (
    .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_sum(out_sum_a), .out_ovf(out_ovf_a), .out_cnt(out_cnt_a)
  );

  lut_acc_i8_i16 #(.N(4), .ACC_W(8)) dut_b (
    .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_sum(out_sum_b), .out_ovf(out_ovf_b), .out_cnt(out_cnt_b)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_hold[i] = 0; m_acc[i] = 0; m_ovf[i] = 0; m_sum[i] = 0; m_sovf[i] = 0;
    end
  endtask

  // One clock of the block-level reference, evaluated with the inputs present at the edge.
  task automatic model_clk();
    longint lo, hi, nv;
    for (int i = 0; i < 2; i++) begin
      lo = -(64'sd1 <<< (wid[i] - 1));
      hi = (64'sd1 <<< (wid[i] - 1)) - 1;
      if (!reset) begin
        m_cnt[i] = 0; m_hold[i] = 0; m_acc[i] = 0; m_ovf[i] = 0; m_sum[i] = 0; m_sovf[i] = 0;
      end else if (clear) begin
        m_cnt[i] = 0; m_hold[i] = 0; m_acc[i] = 0; m_ovf[i] = 0;
      end else if (!m_hold[i] && in_valid) begin
        nv = m_acc[i] + longint'($signed(in_data));
        if (nv > hi) begin nv = nv - (64'sd1 <<< wid[i]); m_ovf[i] = 1; end
        if (nv < lo) begin nv = nv + (64'sd1 <<< wid[i]); m_ovf[i] = 1; end
        m_acc[i] = nv;
        m_cnt[i] = m_cnt[i] + 1;
        if (m_cnt[i] == 4) begin
          m_sum[i] = m_acc[i]; m_sovf[i] = m_ovf[i]; m_hold[i] = 1;
          m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
        end
      end else if (m_hold[i] && out_ready) begin
        m_hold[i] = 0;
      end
    end
  endtask

  task automatic check_all();
    logic [63:0] mask;
    for (int i = 0; i < 2; i++) begin
      mask = (64'd1 << wid[i]) - 64'd1;
      chk($sformatf("in_ready[w%0d]", wid[i]), (i == 0) ? in_ready_a : in_ready_b,
          64'(reset && !m_hold[i]));
      chk($sformatf("out_valid[w%0d]", wid[i]), (i == 0) ? out_valid_a : out_valid_b, 64'(m_hold[i]));
      chk($sformatf("out_cnt[w%0d]", wid[i]), (i == 0) ? out_cnt_a : out_cnt_b, 64'(m_cnt[i]));
      chk($sformatf("out_sum[w%0d]", wid[i]), (i == 0) ? 64'(out_sum_a) : 64'(out_sum_b),
          64'(m_sum[i]) & mask);
      chk($sformatf("out_ovf[w%0d]", wid[i]), (i == 0) ? out_ovf_a : out_ovf_b, 64'(m_sovf[i]));
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic ordy, input logic clr);
    in_valid = v; in_data = d; out_ready = ordy; clear = clr;
    @(posedge clock);
    model_clk();
    @(negedge clock);
    check_all();
  endtask

  initial begin
    model_reset();
    #1 check_all();
    cyc(1'b1, 8'd9, 1'b1, 1'b0);
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    reset = 1'b1;

    // adder result stream 4, 1, -3, 10
    cyc(1'b1, 8'd4, 1'b1, 1'b0);
    cyc(1'b1, 8'd1, 1'b1, 1'b0);
    cyc(1'b1, 8'hFD, 1'b1, 1'b0);
    cyc(1'b1, 8'd10, 1'b1, 1'b0);
    chk("t1_sum", 64'(out_sum_a), 64'h000C);
    chk("t1_valid", 64'(out_valid_a), 64'd1);
    chk("t1_ovf", 64'(out_ovf_a), 64'd0);
    cyc(1'b0, 8'd0, 1'b1, 1'b0);
    chk("t1_ready_after", 64'(in_ready_a), 64'd1);

    // backpressure
    for (int k = 1; k <= 4; k++) cyc(1'b1, 8'(k), 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b1, 8'd7, 1'b0, 1'b0);
    chk("bp_sum", 64'(out_sum_a), 64'd10);
    chk("bp_ready", 64'(in_ready_a), 64'd0);
    cyc(1'b1, 8'd7, 1'b1, 1'b0);
    chk("bp_cnt_handshake", 64'(out_cnt_a), 64'd0);
    cyc(1'b1, 8'd7, 1'b1, 1'b0);
    chk("bp_first_accept", 64'(out_cnt_a), 64'd1);
    for (int k = 0; k < 3; k++) cyc(1'b1, 8'd0, 1'b1, 1'b0);
    cyc(1'b0, 8'd0, 1'b1, 1'b0);

    // overflow on the 8-bit instance
    cyc(1'b1, 8'd127, 1'b1, 1'b0);
    cyc(1'b1, 8'd1, 1'b1, 1'b0);
    cyc(1'b1, 8'd0, 1'b1, 1'b0);
    cyc(1'b1, 8'd0, 1'b1, 1'b0);
    chk("ovf_sum8", 64'(out_sum_b), 64'h80);
    chk("ovf_flag8", 64'(out_ovf_b), 64'd1);
    cyc(1'b1, 8'd1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) cyc(1'b1, 8'd1, 1'b1, 1'b0);
    chk("ovf_next_sum8", 64'(out_sum_b), 64'd4);
    chk("ovf_next_flag8", 64'(out_ovf_b), 64'd0);
    cyc(1'b0, 8'd0, 1'b1, 1'b0);

    // negative accumulation
    for (int k = 0; k < 4; k++) cyc(1'b1, 8'h80, 1'b1, 1'b0);
    chk("neg_sum16", 64'(out_sum_a), 64'hFE00);
    chk("neg_ovf16", 64'(out_ovf_a), 64'd0);
    cyc(1'b0, 8'd0, 1'b1, 1'b0);

    // clear mid-block, then clear during HOLD
    cyc(1'b1, 8'd5, 1'b1, 1'b0);
    cyc(1'b1, 8'd6, 1'b1, 1'b0);
    cyc(1'b1, 8'd9, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) cyc(1'b1, 8'd1, 1'b0, 1'b0);
    chk("clr_sum", 64'(out_sum_a), 64'd4);
    cyc(1'b0, 8'd0, 1'b0, 1'b1);
    chk("clr_hold_valid", 64'(out_valid_a), 64'd0);
    chk("clr_hold_ready", 64'(in_ready_a), 64'd1);

    // async reset mid-block at cnt=3
    for (int k = 0; k < 3; k++) cyc(1'b1, 8'd1, 1'b1, 1'b0);
    chk("rst_pre_cnt", 64'(out_cnt_a), 64'd3);
    #2 reset = 1'b0;
    #1 model_reset();
    check_all();
    chk("rst_ready", 64'(in_ready_a), 64'd0);
    chk("rst_cnt", 64'(out_cnt_a), 64'd0);
    cyc(1'b1, 8'd2, 1'b1, 1'b0);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) cyc(1'b1, 8'd2, 1'b1, 1'b0);
    chk("rst_after_sum", 64'(out_sum_a), 64'd8);
    cyc(1'b0, 8'd0, 1'b1, 1'b0);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      cyc(1'($urandom_range(99, 0) < 70), 8'($urandom), 1'($urandom_range(99, 0) < 60),
          1'($urandom_range(99, 0) < 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
